// File: rtl/eoc_status_monitor.sv
// eoc_status_monitor
// Watches NUM_CH end-of-computation flags after a start pulse. It captures
// each participating channel's return code once, enforces an optional cycle
// watchdog, and reports an aggregated pass/fail/exit code for LEDs, a status
// register or a host mailbox.

module eoc_status_monitor #(
    parameter int NUM_CH      = 4,
    parameter int STATUS_W    = 32,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [NUM_CH-1:0]            ch_mask_i,
    input  logic [CNT_W-1:0]             timeout_i,
    input  logic [NUM_CH-1:0]            eoc_i,
    input  logic [NUM_CH*STATUS_W-1:0]   status_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic                         pass_o,
    output logic [NUM_CH-1:0]            done_vec_o,
    output logic [NUM_CH-1:0]            fail_vec_o,
    output logic [STATUS_W-1:0]          exit_code_o,
    output logic [CNT_W-1:0]             cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [NUM_CH-1:0]     eoc_s;
    logic [STATUS_W-1:0]   status_ch [NUM_CH];
    logic [STATUS_W-1:0]   cap_status_q [NUM_CH];

    logic [NUM_CH-1:0]     mask_q;
    logic [CNT_W-1:0]      timeout_q;
    logic [NUM_CH-1:0]     done_vec_q;
    logic [NUM_CH-1:0]     fail_vec_q;
    logic [CNT_W-1:0]      cycles_q;

    logic                  start_accept;
    logic [NUM_CH-1:0]     capture_vec;
    logic                  complete;
    logic                  wd_hit;
    logic [STATUS_W-1:0]   lowest_fail_code;

    // Flop chain on the EOC levels; depth zero samples the raw inputs directly.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign eoc_s = eoc_i;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

            // Shift the EOC levels through the synchronizer stages.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= eoc_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign eoc_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Split the flat status bus into one word per channel.
    genvar gk;
    generate
        for (gk = 0; gk < NUM_CH; gk++) begin : g_status
            assign status_ch[gk] = status_i[gk*STATUS_W +: STATUS_W];
        end
    endgenerate

    // A start pulse only arms the monitor when it is not already running.
    assign start_accept = start_i && (state_q != ST_RUN);

    // Newly finished participating channels that have not been captured yet.
    assign capture_vec = mask_q & eoc_s & ~done_vec_q;

    // Every participating channel captured; masked-off channels count as done.
    assign complete = &(done_vec_q | ~mask_q);

    // Watchdog fires on the edge where the elapsed count reaches the limit.
    assign wd_hit = (timeout_q != '0) && (cycles_q == (timeout_q - CNT_W'(1)));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and state-decoded status flags; completion beats the watchdog.
    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
                done_o    = (state_q == ST_DONE);
                timeout_o = (state_q == ST_TIMEOUT);
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (complete) begin
                    state_d = ST_DONE;
                end else if (wd_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run configuration, capture vectors, frozen return codes and the elapsed counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= '0;
            timeout_q  <= '0;
            done_vec_q <= '0;
            fail_vec_q <= '0;
            cycles_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cap_status_q[k] <= '0;
            end
        end else if (start_accept) begin
            mask_q     <= ch_mask_i;
            timeout_q  <= timeout_i;
            done_vec_q <= '0;
            fail_vec_q <= '0;
            cycles_q   <= '0;
        end else if (state_q == ST_RUN) begin
            if (cycles_q != '1) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (capture_vec[k]) begin
                    done_vec_q[k]   <= 1'b1;
                    fail_vec_q[k]   <= |status_ch[k];
                    cap_status_q[k] <= status_ch[k];
                end
            end
        end
    end

    // Return code of the lowest-index failing channel, zero when none failed.
    always_comb begin
        lowest_fail_code = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (fail_vec_q[k]) begin
                lowest_fail_code = cap_status_q[k];
            end
        end
    end

    assign pass_o      = (state_q == ST_DONE) && (fail_vec_q == '0);
    assign exit_code_o = (state_q == ST_DONE) ? lowest_fail_code : '1;
    assign done_vec_o  = done_vec_q;
    assign fail_vec_o  = fail_vec_q;
    assign cycles_o    = cycles_q;

endmodule
